// File: rtl/vio_panel_bridge.sv
// Virtual-I/O front end: synchronises and debounces raw pad inputs, flags their edges,
// and offers a once-per-refresh snapshot of the core output bus over valid/ready.
module vio_panel_bridge #(
  parameter int IN_W        = 43,
  parameter int OUT_W       = 82,
  parameter int LED_W       = 3,
  parameter int REFRESH_DIV = 1000,
  parameter int DEBOUNCE    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  pad_in,
  input  logic [OUT_W-1:0] out_data,
  input  logic [IN_W-1:0]  clr_flags,
  input  logic             snap_ready,
  output logic             refresh_o,
  output logic [IN_W-1:0]  in_stable,
  output logic [IN_W-1:0]  in_rise,
  output logic [IN_W-1:0]  in_fall,
  output logic             irq,
  output logic [LED_W-1:0] leds,
  output logic [OUT_W-1:0] out_snap,
  output logic             snap_valid,
  output logic [7:0]       overrun_cnt
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic {IDLE, HOLD} snap_state_t;

  logic [PW-1:0]   pre;
  logic            refresh;
  logic [IN_W-1:0] sync1;
  logic [IN_W-1:0] sync2;
  logic [CW-1:0]   cnt [IN_W];
  logic [IN_W-1:0] commit;
  snap_state_t     state;
  snap_state_t     state_next;
  logic            load;
  logic            overrun_inc;

  assign refresh   = (pre == PW'(REFRESH_DIV - 1));
  assign refresh_o = refresh;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre   <= '0;
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      pre   <= refresh ? '0 : pre + 1'b1;
      sync1 <= pad_in;
      sync2 <= sync1;
    end
  end

  always_comb begin
    commit = '0;
    for (int i = 0; i < IN_W; i++) begin
      commit[i] = refresh && (sync2[i] != in_stable[i]) && (cnt[i] == CW'(DEBOUNCE - 1));
    end
  end

  // NOTE: the counter array is reset explicitly so a reset mid-debounce discards
  // partial counts; arrays without that requirement would be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IN_W; i++) cnt[i] <= '0;
    end else if (refresh) begin
      for (int i = 0; i < IN_W; i++) begin
        if (sync2[i] == in_stable[i] || commit[i]) cnt[i] <= '0;
        else                                        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // A new edge takes priority over a write-1-to-clear landing in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_stable <= '0;
      in_rise   <= '0;
      in_fall   <= '0;
      irq       <= 1'b0;
      leds      <= '0;
    end else begin
      in_stable <= (in_stable & ~commit) | (sync2 & commit);
      in_rise   <= (in_rise & ~clr_flags) | (commit & sync2);
      in_fall   <= (in_fall & ~clr_flags) | (commit & ~sync2);
      irq       <= |(in_rise | in_fall);
      leds      <= in_stable[LED_W-1:0];
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    overrun_inc = 1'b0;
    case (state)
      IDLE: begin
        if (refresh) begin
          load       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (refresh) begin
          load        = 1'b1;
          overrun_inc = !snap_ready;
        end else if (snap_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      out_snap    <= '0;
      overrun_cnt <= '0;
    end else begin
      state <= state_next;
      if (load) out_snap <= out_data;
      if (overrun_inc && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 1'b1;
    end
  end

  assign snap_valid = (state == HOLD);

endmodule

// File: tb/tb_vio_panel_bridge.sv
// Directed bench for vio_panel_bridge with a 4-cycle refresh and 3-sample debounce.
// Inputs are driven and outputs sampled on the falling edge.
module tb_vio_panel_bridge;

  localparam int IN_W  = 8;
  localparam int OUT_W = 82;
  localparam int LED_W = 3;
  localparam logic [OUT_W-1:0] SNAP_A = 82'h22ee_22ee_33ff_33ff;
  localparam logic [OUT_W-1:0] SNAP_B = 82'h3_1234_5678_9abc_def0_1357;

  logic             clk;
  logic             rst;
  logic [IN_W-1:0]  pad_in;
  logic [OUT_W-1:0] out_data;
  logic [IN_W-1:0]  clr_flags;
  logic             snap_ready;
  logic             refresh_o;
  logic [IN_W-1:0]  in_stable;
  logic [IN_W-1:0]  in_rise;
  logic [IN_W-1:0]  in_fall;
  logic             irq;
  logic [LED_W-1:0] leds;
  logic [OUT_W-1:0] out_snap;
  logic             snap_valid;
  logic [7:0]       overrun_cnt;

  int checks = 0;
  int errors = 0;

  vio_panel_bridge #(
    .IN_W(IN_W), .OUT_W(OUT_W), .LED_W(LED_W), .REFRESH_DIV(4), .DEBOUNCE(3)
  ) dut (
    .clk(clk), .rst(rst), .pad_in(pad_in), .out_data(out_data), .clr_flags(clr_flags),
    .snap_ready(snap_ready), .refresh_o(refresh_o), .in_stable(in_stable),
    .in_rise(in_rise), .in_fall(in_fall), .irq(irq), .leds(leds), .out_snap(out_snap),
    .snap_valid(snap_valid), .overrun_cnt(overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench on a falling edge with zero posedges since release (pre == 0).
  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b0;
    pad_in     = '0;
    clr_flags  = '0;
    snap_ready = 1'b0;
    out_data   = '0;
    tick(2);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [2*IN_W+IN_W+OUT_W+LED_W+11:0] all_out;
    do_reset();
    all_out = {refresh_o, in_stable, in_rise, in_fall, irq, leds, out_snap, snap_valid, overrun_cnt};
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (refresh_o !== (k % 4 == 3)) begin
        errors++; $display("FAIL refresh_period k=%0d: got %b expected %b", k, refresh_o, (k % 4 == 3));
      end
      tick(1);
    end
    do_reset();
    pad_in   = 8'hF5;
    out_data = SNAP_B;
    tick(14);
    checks++;
    if ({snap_valid, in_stable, leds} !== {1'b1, 8'hF5, 3'b101}) begin
      errors++; $display("FAIL reset_pre_state: got %b/%h/%b expected 1/f5/101", snap_valid, in_stable, leds);
    end
    rst = 1'b0;
    #1;
    all_out = {refresh_o, in_stable, in_rise, in_fall, irq, leds, out_snap, snap_valid, overrun_cnt};
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_async: got %h expected 0", all_out);
    end
    pad_in   = '0;
    out_data = '0;
    tick(1);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (refresh_o !== (k == 3)) begin
        errors++; $display("FAIL refresh_after_rerelease k=%0d: got %b expected %b", k, refresh_o, (k == 3));
      end
      tick(1);
    end
  endtask

  task automatic test_rise();
    do_reset();
    pad_in[0] = 1'b1;
    tick(11);
    checks++;
    if (in_stable[0] !== 1'b0) begin
      errors++; $display("FAIL rise_early: got %b expected 0", in_stable[0]);
    end
    tick(1);
    checks++;
    if ({in_stable[0], in_rise[0], in_fall[0], irq} !== 4'b1100) begin
      errors++; $display("FAIL rise_commit: got %b expected 1100", {in_stable[0], in_rise[0], in_fall[0], irq});
    end
    tick(1);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL rise_irq: got %b expected 1", irq);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    pad_in[1] = 1'b1;
    tick(7);
    pad_in[1] = 1'b0;
    for (int k = 7; k < 37; k++) begin
      checks++;
      if ({in_stable[1], in_rise[1], irq} !== 3'b000) begin
        errors++; $display("FAIL glitch k=%0d: got %b expected 000", k, {in_stable[1], in_rise[1], irq});
      end
      tick(1);
    end
  endtask

  task automatic test_clear();
    do_reset();
    pad_in[0] = 1'b1;
    tick(12);
    clr_flags[0] = 1'b1;
    tick(1);
    clr_flags[0] = 1'b0;
    checks++;
    if (in_rise[0] !== 1'b0) begin
      errors++; $display("FAIL clear_alone: got %b expected 0", in_rise[0]);
    end
    tick(1);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL clear_irq: got %b expected 0", irq);
    end
    pad_in[0] = 1'b0;
    tick(14);
    checks++;
    if ({in_stable[0], in_fall[0], in_rise[0]} !== 3'b010) begin
      errors++; $display("FAIL fall_commit: got %b expected 010", {in_stable[0], in_fall[0], in_rise[0]});
    end
    pad_in[0] = 1'b1;
    tick(11);
    clr_flags[0] = 1'b1;
    tick(1);
    clr_flags[0] = 1'b0;
    checks++;
    if ({in_stable[0], in_rise[0], in_fall[0]} !== 3'b110) begin
      errors++; $display("FAIL set_beats_clear: got %b expected 110", {in_stable[0], in_rise[0], in_fall[0]});
    end
  endtask

  task automatic test_snapshot();
    do_reset();
    out_data = SNAP_A;
    tick(3);
    checks++;
    if (snap_valid !== 1'b0) begin
      errors++; $display("FAIL snap_before_refresh: got %b expected 0", snap_valid);
    end
    tick(1);
    checks++;
    if ({snap_valid, out_snap, overrun_cnt} !== {1'b1, SNAP_A, 8'd0}) begin
      errors++; $display("FAIL snap_first: got %b/%h/%0d expected 1/%h/0", snap_valid, out_snap, overrun_cnt, SNAP_A);
    end
    tick(8);
    checks++;
    if ({snap_valid, out_snap, overrun_cnt} !== {1'b1, SNAP_A, 8'd2}) begin
      errors++; $display("FAIL snap_overrun: got %b/%h/%0d expected 1/%h/2", snap_valid, out_snap, overrun_cnt, SNAP_A);
    end
    snap_ready = 1'b1;
    tick(1);
    snap_ready = 1'b0;
    checks++;
    if ({snap_valid, overrun_cnt} !== {1'b0, 8'd2}) begin
      errors++; $display("FAIL snap_accept: got %b/%0d expected 0/2", snap_valid, overrun_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_data = SNAP_A;
    tick(4);
    out_data = SNAP_B;
    tick(3);
    checks++;
    if (out_snap !== SNAP_A) begin
      errors++; $display("FAIL snap_stable: got %h expected %h", out_snap, SNAP_A);
    end
    snap_ready = 1'b1;
    tick(1);
    snap_ready = 1'b0;
    checks++;
    if ({snap_valid, out_snap, overrun_cnt} !== {1'b1, SNAP_B, 8'd0}) begin
      errors++; $display("FAIL snap_b2b: got %b/%h/%0d expected 1/%h/0", snap_valid, out_snap, overrun_cnt, SNAP_B);
    end
    tick(4 * 260);
    checks++;
    if (overrun_cnt !== 8'd255) begin
      errors++; $display("FAIL overrun_saturate: got %0d expected 255", overrun_cnt);
    end
  endtask

  task automatic test_leds();
    do_reset();
    pad_in = 8'hF5;
    tick(12);
    checks++;
    if ({in_stable, leds} !== {8'hF5, 3'b000}) begin
      errors++; $display("FAIL leds_lag: got %h/%b expected f5/000", in_stable, leds);
    end
    tick(1);
    checks++;
    if (leds !== 3'b101) begin
      errors++; $display("FAIL leds_follow: got %b expected 101", leds);
    end
    pad_in = 8'h05;
    tick(13);
    checks++;
    if ({in_stable, leds} !== {8'h05, 3'b101}) begin
      errors++; $display("FAIL leds_upper_bits: got %h/%b expected 05/101", in_stable, leds);
    end
  endtask

  initial begin
    rst        = 1'b0;
    pad_in     = '0;
    out_data   = '0;
    clr_flags  = '0;
    snap_ready = 1'b0;
    test_reset();
    test_rise();
    test_glitch();
    test_clear();
    test_snapshot();
    test_back_to_back();
    test_leds();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
